// File: rtl/sqrt_checker.sv
// Verifies an integer square root: squares the root with a shift-and-add multiplier,
// then checks root^2 <= radicand < (root+1)^2. Start-to-done latency is QW+1 clocks.
module sqrt_checker #(
  parameter int RW = 8,
  parameter int QW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [RW-1:0]   radicand,
  input  logic [QW-1:0]   root,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [2*QW-1:0] square,
  output logic [7:0]      fail_count
);

  localparam int CW = $clog2(QW + 1);
  localparam int SW = 2 * QW + 1;

  typedef enum logic [1:0] {IDLE, MUL, CHECK, DONE} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     rad_q, rad_d;
  logic [QW-1:0]     root_q, root_d;
  logic [2*QW-1:0]   mcand_q, mcand_d;
  logic [QW-1:0]     mplier_q, mplier_d;
  logic [2*QW-1:0]   acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [2*QW-1:0]   square_q, square_d;
  logic [7:0]        fail_q, fail_d;

  logic [SW-1:0]     rad_ext;
  logic [SW-1:0]     next_sq;
  logic              chk_pass;

  // (root+1)^2 = root^2 + 2*root + 1, one bit wider so root = 2^QW-1 cannot wrap
  assign rad_ext  = SW'(rad_q);
  assign next_sq  = SW'(acc_q) + (SW'(root_q) << 1) + SW'(1);
  assign chk_pass = (SW'(acc_q) <= rad_ext) && (rad_ext < next_sq);

  always_comb begin
    state_d  = state_q;
    rad_d    = rad_q;
    root_d   = root_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    square_d = square_q;
    fail_d   = fail_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rad_d    = radicand;
          root_d   = root;
          mcand_d  = (2*QW)'(root);
          mplier_d = root;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MUL;
        end
      end
      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1)) state_d = CHECK;
      end
      CHECK: begin
        square_d = acc_q;
        pass_d   = chk_pass;
        if (!chk_pass && fail_q != 8'hFF) fail_d = fail_q + 8'd1;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rad_q    <= '0;
      root_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      square_q <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      rad_q    <= rad_d;
      root_q   <= root_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      square_q <= square_d;
      fail_q   <= fail_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign square     = square_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_sqrt_checker.sv
// Directed and randomized checks of sqrt_checker against an arithmetic reference.
module tb_sqrt_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  radicand = '0;
  logic [7:0]  root = '0;
  logic        busy, done, pass;
  logic [15:0] square;
  logic [7:0]  fail_count;

  int errors = 0;
  int checks = 0;
  int exp_fail = 0;

  sqrt_checker #(.RW(8), .QW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .radicand(radicand), .root(root),
    .busy(busy), .done(done), .pass(pass), .square(square), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full check; optionally re-pulses start with other operands mid-operation.
  task automatic do_op(input logic [7:0] rad, input logic [7:0] rt, input bit inject);
    int cyc;
    int busy_cnt;
    int done_cnt;
    int exp_sq;
    bit exp_pass;
    exp_sq   = int'(rt) * int'(rt);
    exp_pass = (exp_sq <= int'(rad)) && (int'(rad) < (int'(rt) + 1) * (int'(rt) + 1));
    if (!exp_pass && exp_fail < 255) exp_fail++;
    radicand = rad;
    root     = rt;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cyc      = 1;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    while (!done && cyc < 20) begin
      if (inject && (cyc == 3 || cyc == 9)) begin
        start    = 1'b1;
        radicand = ~rad;
        root     = rt + 8'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    if (done) done_cnt++;
    chk("latency", cyc - 1, 9);
    chk("busy_len", busy_cnt, 10);
    chk("square", square, exp_sq);
    chk("pass", pass, exp_pass);
    chk("fail_count", fail_count, exp_fail);
    tick();
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    if (inject) begin
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done) done_cnt++;
      end
      chk("single_done", done_cnt, 1);
      chk("square_hold", square, exp_sq);
    end
  endtask

  initial begin
    int saw_done;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_square", square, 0);
    chk("rst_fail", fail_count, 0);
    reset = 1'b0;
    tick();

    do_op(8'd200, 8'd14, 1'b0);
    do_op(8'd200, 8'd15, 1'b0);
    do_op(8'd200, 8'd13, 1'b0);
    do_op(8'd0,   8'd0,  1'b0);
    do_op(8'd255, 8'd15, 1'b0);
    do_op(8'd255, 8'd255, 1'b0);
    do_op(8'd100, 8'd10, 1'b1);
    do_op(8'd50,  8'd9,  1'b1);

    // Asynchronous reset mid-multiply
    radicand = 8'd200;
    root     = 8'd14;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_square", square, 0);
    chk("arst_fail", fail_count, 0);
    exp_fail = 0;
    tick();
    reset = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) saw_done++;
    end
    chk("arst_no_done", saw_done, 0);
    do_op(8'd200, 8'd14, 1'b0);

    for (int i = 0; i < 40; i++)
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 16)), 1'b0);

    // Guaranteed failures: root >= 16 squares above any 8-bit radicand
    for (int i = 0; i < 260; i++)
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(16, 255)), 1'b0);
    chk("fail_sat", fail_count, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
